sparc_rst_seq: RTL and testbench
================================

Name: sparc_rst_seq

Overview:
- Parametrised multi-core reset/clock-enable sequencer for the FPGA SPARC subsystem.
- Replaces the fixed single-core delay counter with per-core staged sequencing, staggered core start, per-core enable, and a warm-reset handshake.
- Sits between the board-level reset and N SPARC core instances, and drives each core's cmp_arst_l/adbginit_l, cluster_cken, ctu_tst_pre_grst_l, cmp_grst_l and gdbginit_l.

Parameters:
N_CORES, 4, number of cores sequenced
CNT_W, 8, per-core counter width
CKEN_DLY, 21, cycles from arst release to cluster_cken high
PRE_GRST_DLY, 61, cycles from arst release to ctu_tst_pre_grst_l high
GRST_DLY, 121, cycles from arst release to cmp_grst_l/gdbginit_l high
STAGGER, 8, extra start delay per core index (core i waits i*STAGGER)
WARM_HOLD, 60, cycles cmp_grst_l/gdbginit_l are held low on warm reset

Ports:
gclk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
core_en  in  N_CORES  per-core enable; 0 holds that core in full reset
warm_rst_req  in  N_CORES  per-core warm-reset request, level or pulse
warm_rst_ack  out  N_CORES  one-cycle pulse when warm reset completes
cmp_arst_l  out  N_CORES  async-domain reset, active-low
adbginit_l  out  N_CORES  equal to cmp_arst_l
cluster_cken  out  N_CORES  cluster clock enable
ctu_tst_pre_grst_l  out  N_CORES  pre-global reset, active-low
cmp_grst_l  out  N_CORES  global reset, active-low
gdbginit_l  out  N_CORES  equal to cmp_grst_l
all_ready  out  1  every enabled core is in RUN and at least one core is enabled

Behaviour:
- All outputs are registered. Reset values: every output 0. This asserts all active-low resets and holds cken off.
- Per-core FSM, all cores identical.
  - OFF: entered on reset or when core_en[i]=0. cnt=0.
  - WAIT: cnt counts to i*STAGGER.
  - SEQ: cnt counts 0..GRST_DLY, then saturates.
  - RUN: the core is out of reset.
  - WARM: cnt counts 0..WARM_HOLD-1.
- Transitions:
  - OFF->WAIT when core_en[i]=1.
  - WAIT->SEQ when cnt==i*STAGGER. Core 0 goes directly to SEQ. cnt clears on entry to SEQ.
  - SEQ->RUN when cnt==GRST_DLY.
  - RUN->WARM when warm_rst_req[i]=1. cnt clears on entry.
  - WARM->RUN when cnt==WARM_HOLD-1. warm_rst_ack[i] pulses for 1 cycle on the cycle RUN is entered.
- Output rules, timed from registered state:
  - cmp_arst_l/adbginit_l are 1 in SEQ, RUN and WARM.
  - cluster_cken is 1 when in SEQ with cnt>=CKEN_DLY, and in RUN/WARM.
  - ctu_tst_pre_grst_l is 1 when in SEQ with cnt>=PRE_GRST_DLY, and in RUN/WARM.
  - cmp_grst_l/gdbginit_l are 1 in RUN only.
  - In WARM, cken, pre_grst_l and arst_l all stay 1.
- Timing: reset deasserted at cycle 0 with core_en=all-ones.
  - Core i arst_l rises at cycle i*STAGGER+2.
  - cken rises CKEN_DLY cycles after arst_l.
  - pre_grst_l rises PRE_GRST_DLY cycles after arst_l.
  - grst_l rises GRST_DLY cycles after arst_l.
- Boundary conditions:
  - core_en[i] falling in any state: next cycle OFF, all of that core's outputs 0, no ack. This takes priority over a simultaneous warm_rst_req.
  - warm_rst_req outside RUN is ignored and not latched.
  - warm_rst_req held high: the core re-enters WARM on the cycle after each ack.
  - reset mid-operation: every core goes to OFF next cycle, regardless of state.
- all_ready = (&(~core_en | run)) & (|core_en). Registered, one cycle after the last enabled core reaches RUN.
- Elaboration checks; fatal if violated:
  - CKEN_DLY < PRE_GRST_DLY < GRST_DLY < 2^CNT_W.
  - (N_CORES-1)*STAGGER < 2^CNT_W.
  - 1 <= WARM_HOLD < 2^CNT_W.

Optional Feature:
- RST_SEQ_REQ_SYNC_EN defined:
  - warm_rst_req and core_en each pass through a 2-flop synchronizer in gclk before the FSM. Synchronizer flops reset to 0.
  - All input-to-output latencies grow by 2 cycles.
- Undefined: inputs are used directly and are assumed to be in the gclk domain.

Decomposition:
- Package sparc_rst_seq_pkg holds:
  - the state enum (OFF, WAIT, SEQ, RUN, WARM) and its width constant;
  - default delay constants.
- Sub-module sparc_rst_seq_core: one FSM, counter and output register set, with core index passed as a parameter.
- The top instantiates N_CORES copies in a generate loop and builds all_ready.

Test Plan:
- Cold start, N_CORES=4, STAGGER=8, core_en=4'hF, reset released at cycle 0:
  - core 0 arst_l=1 at cycle 2, cken at 23, pre_grst_l at 63, grst_l at 123;
  - core 3 grst_l at 147;
  - all_ready at 148.
- Partial enable, core_en=4'b0101: cores 1 and 3 keep all outputs 0; all_ready=1 one cycle after core 2 reaches RUN.
- Warm reset, 1-cycle warm_rst_req[1] pulse in RUN, WARM_HOLD=60:
  - core 1 grst_l=0 for 60 cycles, cken/arst_l stay 1;
  - ack pulses 1 cycle, coincident with grst_l returning to 1;
  - all_ready drops during WARM.
- core_en[2] dropped mid-SEQ, at cnt=40, with warm_rst_req[2] asserted the same cycle: next cycle all core 2 outputs 0, no ack; re-enabling restarts the full sequence.
- reset asserted while cores are in RUN/WARM: next cycle all outputs 0, no acks; the sequence replays exactly as in the cold-start scenario.
- With RST_SEQ_REQ_SYNC_EN defined: repeat the cold-start scenario; every edge is 2 cycles later than without the macro.

Source files
------------

// File: rtl/sparc_rst_seq_pkg.sv
// Shared state encoding and default delay settings for the multi-core SPARC reset sequencer.
package sparc_rst_seq_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        ST_OFF  = 3'd0,
        ST_WAIT = 3'd1,
        ST_SEQ  = 3'd2,
        ST_RUN  = 3'd3,
        ST_WARM = 3'd4
    } state_e;

    localparam logic [ST_W-1:0] S_OFF  = ST_OFF;
    localparam logic [ST_W-1:0] S_WAIT = ST_WAIT;
    localparam logic [ST_W-1:0] S_SEQ  = ST_SEQ;
    localparam logic [ST_W-1:0] S_RUN  = ST_RUN;
    localparam logic [ST_W-1:0] S_WARM = ST_WARM;

    localparam int DEF_N_CORES      = 4;
    localparam int DEF_CNT_W        = 8;
    localparam int DEF_CKEN_DLY     = 21;
    localparam int DEF_PRE_GRST_DLY = 61;
    localparam int DEF_GRST_DLY     = 121;
    localparam int DEF_STAGGER      = 8;
    localparam int DEF_WARM_HOLD    = 60;

    function automatic logic fits_cnt(input int value, input int cnt_w);
        return (value >= 0) && (value < (1 << cnt_w));
    endfunction

endpackage

// File: rtl/sparc_rst_seq_if.sv
// Per-core enable/warm-reset handshake and reset/clock-enable outputs of the sequencer.
interface sparc_rst_seq_if #(
    parameter int N_CORES = 4
);
    logic [N_CORES-1:0] core_en;
    logic [N_CORES-1:0] warm_rst_req;
    logic [N_CORES-1:0] warm_rst_ack;
    logic [N_CORES-1:0] cmp_arst_l;
    logic [N_CORES-1:0] adbginit_l;
    logic [N_CORES-1:0] cluster_cken;
    logic [N_CORES-1:0] ctu_tst_pre_grst_l;
    logic [N_CORES-1:0] cmp_grst_l;
    logic [N_CORES-1:0] gdbginit_l;
    logic               all_ready;

    modport master (
        output core_en, warm_rst_req,
        input  warm_rst_ack, cmp_arst_l, adbginit_l, cluster_cken,
               ctu_tst_pre_grst_l, cmp_grst_l, gdbginit_l, all_ready
    );

    modport slave (
        input  core_en, warm_rst_req,
        output warm_rst_ack, cmp_arst_l, adbginit_l, cluster_cken,
               ctu_tst_pre_grst_l, cmp_grst_l, gdbginit_l, all_ready
    );
endinterface

// File: rtl/sparc_rst_seq_core.sv
// One core's reset FSM, shared phase counter and registered reset/cken outputs.
//   state | meaning
//   OFF   | core disabled or board reset; every output low
//   WAIT  | stagger delay, cnt runs to IDX*STAGGER
//   SEQ   | arst released; cken, pre_grst, grst released as cnt climbs
//   RUN   | core fully out of reset
//   WARM  | grst held low for WARM_HOLD cycles, clocks and arst stay up
module sparc_rst_seq_core
    import sparc_rst_seq_pkg::*;
#(
    parameter int IDX          = 0,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int CKEN_DLY     = DEF_CKEN_DLY,
    parameter int PRE_GRST_DLY = DEF_PRE_GRST_DLY,
    parameter int GRST_DLY     = DEF_GRST_DLY,
    parameter int STAGGER      = DEF_STAGGER,
    parameter int WARM_HOLD    = DEF_WARM_HOLD
) (
    input  logic gclk,
    input  logic reset,
    input  logic en,
    input  logic req,
    output logic ack,
    output logic arst_l,
    output logic cken,
    output logic pre_grst_l,
    output logic grst_l
);

    localparam logic [CNT_W-1:0] WAIT_TC = CNT_W'(IDX * STAGGER);
    localparam logic [CNT_W-1:0] CKEN_TC = CNT_W'(CKEN_DLY);
    localparam logic [CNT_W-1:0] PRE_TC  = CNT_W'(PRE_GRST_DLY);
    localparam logic [CNT_W-1:0] SEQ_TC  = CNT_W'(GRST_DLY - 1);
    localparam logic [CNT_W-1:0] WARM_TC = CNT_W'(WARM_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [ST_W-1:0]  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             warm_exit_q, warm_exit_d;
    logic             ack_q, ack_d;
    logic             arst_q, arst_d;
    logic             cken_q, cken_d;
    logic             pre_q, pre_d;
    logic             grst_q, grst_d;
    logic             in_seq, in_up;

    assign in_seq = (state_q == S_SEQ);
    assign in_up  = (state_q == S_RUN) || (state_q == S_WARM);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        warm_exit_d = 1'b0;
        if (!en) begin
            state_d = S_OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
                S_WAIT: begin
                    if (cnt_q == WAIT_TC) begin
                        state_d = S_SEQ;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                // cnt lands on GRST_DLY as RUN is entered and is left there
                S_SEQ: begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == SEQ_TC) state_d = S_RUN;
                end
                S_RUN: begin
                    if (req) begin
                        state_d = S_WARM;
                        cnt_d   = '0;
                    end
                end
                S_WARM: begin
                    if (cnt_q == WARM_TC) begin
                        state_d     = S_RUN;
                        warm_exit_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs decode the registered state; ack is delayed one cycle so it lines up with grst_l rising.
    always_comb begin
        arst_d = en && (in_seq || in_up);
        cken_d = en && ((in_seq && (cnt_q >= CKEN_TC)) || in_up);
        pre_d  = en && ((in_seq && (cnt_q >= PRE_TC)) || in_up);
        grst_d = en && (state_q == S_RUN);
        ack_d  = en && warm_exit_q;
    end

    always_ff @(posedge gclk) begin
        if (reset) begin
            state_q     <= S_OFF;
            cnt_q       <= '0;
            warm_exit_q <= 1'b0;
            ack_q       <= 1'b0;
            arst_q      <= 1'b0;
            cken_q      <= 1'b0;
            pre_q       <= 1'b0;
            grst_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            warm_exit_q <= warm_exit_d;
            ack_q       <= ack_d;
            arst_q      <= arst_d;
            cken_q      <= cken_d;
            pre_q       <= pre_d;
            grst_q      <= grst_d;
        end
    end

    assign ack        = ack_q;
    assign arst_l     = arst_q;
    assign cken       = cken_q;
    assign pre_grst_l = pre_q;
    assign grst_l     = grst_q;

endmodule

// File: rtl/sparc_rst_seq.sv
// Multi-core SPARC reset/clock-enable sequencer: one staggered FSM per core plus all_ready.
// Define RST_SEQ_REQ_SYNC_EN to pass core_en and warm_rst_req through 2-flop gclk synchronizers.
module sparc_rst_seq
    import sparc_rst_seq_pkg::*;
#(
    parameter int N_CORES      = DEF_N_CORES,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int CKEN_DLY     = DEF_CKEN_DLY,
    parameter int PRE_GRST_DLY = DEF_PRE_GRST_DLY,
    parameter int GRST_DLY     = DEF_GRST_DLY,
    parameter int STAGGER      = DEF_STAGGER,
    parameter int WARM_HOLD    = DEF_WARM_HOLD
) (
    input  logic             gclk,
    input  logic             reset,
    sparc_rst_seq_if.slave   bus
);

    if (!(CKEN_DLY < PRE_GRST_DLY && PRE_GRST_DLY < GRST_DLY && fits_cnt(GRST_DLY, CNT_W)))
    begin : g_bad_dly
        $fatal(1, "sparc_rst_seq: need CKEN_DLY < PRE_GRST_DLY < GRST_DLY < 2**CNT_W");
    end
    if (!fits_cnt((N_CORES - 1) * STAGGER, CNT_W)) begin : g_bad_stagger
        $fatal(1, "sparc_rst_seq: (N_CORES-1)*STAGGER must fit in CNT_W bits");
    end
    if (WARM_HOLD < 1 || !fits_cnt(WARM_HOLD, CNT_W)) begin : g_bad_warm
        $fatal(1, "sparc_rst_seq: WARM_HOLD must be in 1 .. 2**CNT_W-1");
    end

    logic [N_CORES-1:0] core_en_i, req_i;
    logic [N_CORES-1:0] ack_v, arst_v, cken_v, pre_v, grst_v;
    logic               all_ready_q, all_ready_d;

`ifdef RST_SEQ_REQ_SYNC_EN
    logic [N_CORES-1:0] en_s1_q, en_s1_d, en_s2_q, en_s2_d;
    logic [N_CORES-1:0] req_s1_q, req_s1_d, req_s2_q, req_s2_d;

    always_comb begin
        en_s1_d  = bus.core_en;
        en_s2_d  = en_s1_q;
        req_s1_d = bus.warm_rst_req;
        req_s2_d = req_s1_q;
    end

    always_ff @(posedge gclk) begin
        if (reset) begin
            en_s1_q  <= '0;
            en_s2_q  <= '0;
            req_s1_q <= '0;
            req_s2_q <= '0;
        end else begin
            en_s1_q  <= en_s1_d;
            en_s2_q  <= en_s2_d;
            req_s1_q <= req_s1_d;
            req_s2_q <= req_s2_d;
        end
    end

    assign core_en_i = en_s2_q;
    assign req_i     = req_s2_q;
`else
    assign core_en_i = bus.core_en;
    assign req_i     = bus.warm_rst_req;
`endif

    for (genvar i = 0; i < N_CORES; i++) begin : g_core
        sparc_rst_seq_core #(
            .IDX          (i),
            .CNT_W        (CNT_W),
            .CKEN_DLY     (CKEN_DLY),
            .PRE_GRST_DLY (PRE_GRST_DLY),
            .GRST_DLY     (GRST_DLY),
            .STAGGER      (STAGGER),
            .WARM_HOLD    (WARM_HOLD)
        ) u_core (
            .gclk       (gclk),
            .reset      (reset),
            .en         (core_en_i[i]),
            .req        (req_i[i]),
            .ack        (ack_v[i]),
            .arst_l     (arst_v[i]),
            .cken       (cken_v[i]),
            .pre_grst_l (pre_v[i]),
            .grst_l     (grst_v[i])
        );
    end

    // grst_v is already registered, so all_ready trails the last core's RUN by one cycle.
    always_comb begin
        all_ready_d = (&(~core_en_i | grst_v)) & (|core_en_i);
    end

    always_ff @(posedge gclk) begin
        if (reset) all_ready_q <= 1'b0;
        else       all_ready_q <= all_ready_d;
    end

    assign bus.warm_rst_ack       = ack_v;
    assign bus.cmp_arst_l         = arst_v;
    assign bus.adbginit_l         = arst_v;
    assign bus.cluster_cken       = cken_v;
    assign bus.ctu_tst_pre_grst_l = pre_v;
    assign bus.cmp_grst_l         = grst_v;
    assign bus.gdbginit_l         = grst_v;
    assign bus.all_ready          = all_ready_q;

endmodule

// File: tb/tb_sparc_rst_seq.sv
// Bench for sparc_rst_seq: timeline-based reference model plus scenario tasks with random stimulus.
module tb_sparc_rst_seq;

    localparam int N    = 4;
    localparam int CKEN = 21;
    localparam int PRE  = 61;
    localparam int GRST = 121;
    localparam int STG  = 8;
    localparam int WH   = 60;
`ifdef RST_SEQ_REQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic gclk = 1'b0;
    logic reset;
    always #5 gclk = ~gclk;

    sparc_rst_seq_if #(.N_CORES(N)) bus ();

    sparc_rst_seq #(
        .N_CORES(N), .CNT_W(8), .CKEN_DLY(CKEN), .PRE_GRST_DLY(PRE),
        .GRST_DLY(GRST), .STAGGER(STG), .WARM_HOLD(WH)
    ) dut (
        .gclk  (gclk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: each core is off, in a cold timeline started at m_ref, or in a warm hold started at m_ref.
    int m_mode [N];
    int m_ref  [N];
    logic [N-1:0] m_en_s1 = '0, m_en_s2 = '0, m_req_s1 = '0, m_req_s2 = '0;
    logic [N-1:0] e_arst = '0, e_cken = '0, e_pre = '0, e_grst = '0, e_ack = '0;
    logic         e_rdy = 1'b0;

    logic [7*N:0] dut_vec, exp_vec;
    assign dut_vec = {bus.cmp_arst_l, bus.adbginit_l, bus.cluster_cken, bus.ctu_tst_pre_grst_l,
                      bus.cmp_grst_l, bus.gdbginit_l, bus.warm_rst_ack, bus.all_ready};
    assign exp_vec = {e_arst, e_arst, e_cken, e_pre, e_grst, e_grst, e_ack, e_rdy};

    task automatic model_step();
        logic [N-1:0] en_eff, req_eff, prev_grst;
        int d, base;
`ifdef RST_SEQ_REQ_SYNC_EN
        en_eff  = m_en_s2;
        req_eff = m_req_s2;
        if (reset) begin
            m_en_s1 = '0; m_en_s2 = '0; m_req_s1 = '0; m_req_s2 = '0;
        end else begin
            m_en_s2 = m_en_s1; m_en_s1 = bus.core_en;
            m_req_s2 = m_req_s1; m_req_s1 = bus.warm_rst_req;
        end
`else
        en_eff  = bus.core_en;
        req_eff = bus.warm_rst_req;
`endif
        prev_grst = e_grst;
        e_rdy = !reset && (&(~en_eff | prev_grst)) && (|en_eff);
        for (int i = 0; i < N; i++) begin
            e_arst[i] = 1'b0; e_cken[i] = 1'b0; e_pre[i] = 1'b0; e_grst[i] = 1'b0; e_ack[i] = 1'b0;
            if (reset || !en_eff[i]) begin
                m_mode[i] = 0;
            end else if (m_mode[i] == 0) begin
                m_mode[i] = 1;
                m_ref[i]  = cyc;
            end else begin
                d = cyc - m_ref[i];
                if (m_mode[i] == 1) begin
                    base = i * STG + 2;
                    e_arst[i] = (d >= base);
                    e_cken[i] = (d >= base + CKEN);
                    e_pre[i]  = (d >= base + PRE);
                    e_grst[i] = (d >= base + GRST);
                end else begin
                    e_arst[i] = 1'b1; e_cken[i] = 1'b1; e_pre[i] = 1'b1;
                    e_grst[i] = (d >= WH + 1);
                    e_ack[i]  = (d == WH + 1);
                end
                if (e_grst[i] && req_eff[i]) begin
                    m_mode[i] = 2;
                    m_ref[i]  = cyc;
                end
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge gclk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.core_en = '1;
        bus.warm_rst_req = N'($urandom);
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (dut_vec !== '0) begin
                n_fail++;
                $display("FAIL reset_zero cyc=%0d got=%h exp=0", cyc - 1, dut_vec);
            end
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc - 1, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_cold_start(input string tag);
        int rel0, rel;
        int f_arst0 = -1, f_cken0 = -1, f_pre0 = -1, f_grst0 = -1, f_grst3 = -1, f_rdy = -1;
        bus.core_en = '1;
        bus.warm_rst_req = '0;
        reset = 1'b0;
        rel0 = cyc;
        for (int k = 0; k < 170; k++) begin
            tick();
            rel = cyc - 1 - rel0;
            if (f_arst0 < 0 && bus.cmp_arst_l[0] === 1'b1) f_arst0 = rel;
            if (f_cken0 < 0 && bus.cluster_cken[0] === 1'b1) f_cken0 = rel;
            if (f_pre0 < 0 && bus.ctu_tst_pre_grst_l[0] === 1'b1) f_pre0 = rel;
            if (f_grst0 < 0 && bus.cmp_grst_l[0] === 1'b1) f_grst0 = rel;
            if (f_grst3 < 0 && bus.cmp_grst_l[3] === 1'b1) f_grst3 = rel;
            if (f_rdy < 0 && bus.all_ready === 1'b1) f_rdy = rel;
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL %s_model rel=%0d got=%h exp=%h", tag, rel, dut_vec, exp_vec);
            end
        end
        n_checks++;
        if (f_arst0 != 2 + LAT) begin
            n_fail++; $display("FAIL %s_arst0_rise got=%0d exp=%0d", tag, f_arst0, 2 + LAT);
        end
        n_checks++;
        if (f_cken0 != 23 + LAT) begin
            n_fail++; $display("FAIL %s_cken0_rise got=%0d exp=%0d", tag, f_cken0, 23 + LAT);
        end
        n_checks++;
        if (f_pre0 != 63 + LAT) begin
            n_fail++; $display("FAIL %s_pre0_rise got=%0d exp=%0d", tag, f_pre0, 63 + LAT);
        end
        n_checks++;
        if (f_grst0 != 123 + LAT) begin
            n_fail++; $display("FAIL %s_grst0_rise got=%0d exp=%0d", tag, f_grst0, 123 + LAT);
        end
        n_checks++;
        if (f_grst3 != 147 + LAT) begin
            n_fail++; $display("FAIL %s_grst3_rise got=%0d exp=%0d", tag, f_grst3, 147 + LAT);
        end
        n_checks++;
        if (f_rdy != 148 + LAT) begin
            n_fail++; $display("FAIL %s_all_ready_rise got=%0d exp=%0d", tag, f_rdy, 148 + LAT);
        end
    endtask

    task automatic test_warm();
        int t0, grst_low = 0, ack_cnt = 0, ack_at = -1, rise_at = -1, up_low = 0, rdy_low = 0;
        bus.warm_rst_req = 4'b0010;
        t0 = cyc;
        for (int k = 0; k < 76; k++) begin
            tick();
            bus.warm_rst_req = '0;
            if (bus.cmp_grst_l[1] === 1'b0) grst_low++;
            if (bus.cmp_grst_l[1] === 1'b1 && grst_low > 0 && rise_at < 0) rise_at = cyc - 1;
            if (bus.warm_rst_ack[1] === 1'b1) begin ack_cnt++; ack_at = cyc - 1; end
            if (bus.cluster_cken[1] !== 1'b1 || bus.cmp_arst_l[1] !== 1'b1) up_low++;
            if (bus.all_ready !== 1'b1) rdy_low++;
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL warm_model cyc=%0d got=%h exp=%h", cyc - 1, dut_vec, exp_vec);
            end
        end
        n_checks++;
        if (grst_low != WH) begin n_fail++; $display("FAIL warm_grst_low got=%0d exp=%0d", grst_low, WH); end
        n_checks++;
        if (ack_cnt != 1) begin n_fail++; $display("FAIL warm_ack_count got=%0d exp=1", ack_cnt); end
        n_checks++;
        if (ack_at != t0 + WH + 1 + LAT) begin
            n_fail++; $display("FAIL warm_ack_cycle got=%0d exp=%0d", ack_at, t0 + WH + 1 + LAT);
        end
        n_checks++;
        if (rise_at != t0 + WH + 1 + LAT) begin
            n_fail++; $display("FAIL warm_grst_return got=%0d exp=%0d", rise_at, t0 + WH + 1 + LAT);
        end
        n_checks++;
        if (up_low != 0) begin n_fail++; $display("FAIL warm_cken_arst_drop got=%0d exp=0", up_low); end
        n_checks++;
        if (rdy_low != WH) begin n_fail++; $display("FAIL warm_all_ready_low got=%0d exp=%0d", rdy_low, WH); end
    endtask

    task automatic test_partial_enable();
        int rel0, f_rdy = -1, leak = 0;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        bus.core_en = 4'b0101;
        bus.warm_rst_req = '0;
        rel0 = cyc;
        for (int k = 0; k < 170; k++) begin
            tick();
            if ({bus.cmp_arst_l[1], bus.cmp_arst_l[3], bus.cluster_cken[1], bus.cluster_cken[3],
                 bus.ctu_tst_pre_grst_l[1], bus.ctu_tst_pre_grst_l[3],
                 bus.cmp_grst_l[1], bus.cmp_grst_l[3]} !== 8'h00) leak++;
            if (f_rdy < 0 && bus.all_ready === 1'b1) f_rdy = cyc - 1 - rel0;
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL partial_model cyc=%0d got=%h exp=%h", cyc - 1, dut_vec, exp_vec);
            end
        end
        n_checks++;
        if (leak != 0) begin n_fail++; $display("FAIL partial_disabled_outputs got=%0d exp=0", leak); end
        n_checks++;
        if (f_rdy != 140 + LAT) begin
            n_fail++; $display("FAIL partial_all_ready_rise got=%0d exp=%0d", f_rdy, 140 + LAT);
        end
    endtask

    task automatic test_en_drop();
        int rel1, acks = 0, f_arst2 = -1, f_grst2 = -1;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        bus.core_en = '1;
        bus.warm_rst_req = '0;
        repeat (58) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL drop_pre_model cyc=%0d got=%h exp=%h", cyc - 1, dut_vec, exp_vec);
            end
        end
        n_checks++;
        if (bus.cluster_cken[2] !== 1'b1) begin
            n_fail++; $display("FAIL drop_cken2_before got=%b exp=1", bus.cluster_cken[2]);
        end
        bus.core_en = 4'b1011;
        bus.warm_rst_req = 4'b0100;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (bus.warm_rst_ack !== '0) acks++;
            if (j == LAT) begin
                n_checks++;
                if ({bus.cmp_arst_l[2], bus.cluster_cken[2], bus.ctu_tst_pre_grst_l[2],
                     bus.cmp_grst_l[2]} !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL drop_core2_off got=%b%b%b%b exp=0000", bus.cmp_arst_l[2],
                             bus.cluster_cken[2], bus.ctu_tst_pre_grst_l[2], bus.cmp_grst_l[2]);
                end
            end
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL drop_model cyc=%0d got=%h exp=%h", cyc - 1, dut_vec, exp_vec);
            end
        end
        n_checks++;
        if (acks != 0) begin n_fail++; $display("FAIL drop_no_ack got=%0d exp=0", acks); end
        bus.core_en = '1;
        bus.warm_rst_req = '0;
        rel1 = cyc;
        for (int k = 0; k < 170; k++) begin
            tick();
            if (f_arst2 < 0 && bus.cmp_arst_l[2] === 1'b1) f_arst2 = cyc - 1 - rel1;
            if (f_grst2 < 0 && bus.cmp_grst_l[2] === 1'b1) f_grst2 = cyc - 1 - rel1;
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL reenable_model cyc=%0d got=%h exp=%h", cyc - 1, dut_vec, exp_vec);
            end
        end
        n_checks++;
        if (f_arst2 != 2 * STG + 2 + LAT) begin
            n_fail++; $display("FAIL reenable_arst2 got=%0d exp=%0d", f_arst2, 2 * STG + 2 + LAT);
        end
        n_checks++;
        if (f_grst2 != 2 * STG + 2 + GRST + LAT) begin
            n_fail++; $display("FAIL reenable_grst2 got=%0d exp=%0d", f_grst2, 2 * STG + 2 + GRST + LAT);
        end
    endtask

    task automatic test_random();
        reset = 1'b0;
        bus.core_en = '1;
        bus.warm_rst_req = '0;
        for (int k = 0; k < 2500; k++) begin
            int idx, r;
            if ($urandom_range(0, 299) == 0) begin
                idx = $urandom_range(0, N - 1);
                bus.core_en[idx] = ~bus.core_en[idx];
            end
            r = $urandom_range(0, 9);
            if (r < 2) bus.warm_rst_req = N'($urandom) & N'($urandom);
            else if (r < 7) bus.warm_rst_req = '0;
            reset = ($urandom_range(0, 999) == 0);
            tick();
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc - 1, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b0;
        bus.core_en = '1;
        bus.warm_rst_req = '0;
        for (int k = 0; k < 211; k++) begin
            if (k == 200) bus.warm_rst_req = 4'b0101;
            if (k == 201) bus.warm_rst_req = '0;
            tick();
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL mid_model cyc=%0d got=%h exp=%h", cyc - 1, dut_vec, exp_vec);
            end
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (dut_vec !== '0) begin
            n_fail++; $display("FAIL mid_reset_zero got=%h exp=0", dut_vec);
        end
        tick();
        test_cold_start("replay");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.core_en = '1;
        bus.warm_rst_req = '0;
        for (int i = 0; i < N; i++) begin
            m_mode[i] = 0;
            m_ref[i]  = 0;
        end
        test_reset();
        test_cold_start("cold");
        test_warm();
        test_partial_enable();
        test_en_drop();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
